// File: rtl/defines.sv
// Shared pipeline definitions: stage-register FSM states and the packed
// per-stage payload layouts that feed pipe_stage_skid's DATA_WIDTH.
package defines;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_HALF  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_payload_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } id_ex_payload_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [31:0] wb_val;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_payload_t;

    localparam int IF_ID_W  = $bits(if_id_payload_t);
    localparam int ID_EX_W  = $bits(id_ex_payload_t);
    localparam int EX_MEM_W = $bits(ex_mem_payload_t);
    localparam int MEM_WB_W = $bits(mem_wb_payload_t);

    // Number of payloads held in a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            PS_HALF: occ = 2'd1;
            PS_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer, synchronous
// flush and a saturating stall counter; all outputs come straight from flops.
module pipe_stage_skid
    import defines::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CNT_WIDTH   = 16,
    parameter bit BUBBLE_ZERO = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  up_valid_i,
    output logic                  up_ready_o,
    input  logic [DATA_WIDTH-1:0] up_data_i,
    output logic                  dn_valid_o,
    input  logic                  dn_ready_i,
    output logic [DATA_WIDTH-1:0] dn_data_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

    // Handshake: a payload moves on a port only in a cycle where both valid
    // and ready are high at the rising edge; valid never waits on ready.

    pipe_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_WIDTH-1:0]  stall_q, stall_d;
    logic                  up_ready_q, dn_valid_q;
    logic [1:0]            occ_q;
    logic                  up_hs, dn_hs, stall;

    assign up_hs = up_valid_i & up_ready_q;
    assign dn_hs = dn_valid_q & dn_ready_i;
    assign stall = dn_valid_q & ~dn_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            PS_EMPTY: begin
                if (up_hs) begin
                    state_d = PS_HALF;
                    main_d  = up_data_i;
                end
            end
            PS_HALF: begin
                if (up_hs && dn_hs) begin
                    main_d = up_data_i;
                end else if (up_hs) begin
                    state_d = PS_FULL;
                    skid_d  = up_data_i;
                end else if (dn_hs) begin
                    state_d = PS_EMPTY;
                    if (BUBBLE_ZERO) begin
                        main_d = '0;
                    end
                end
            end
            PS_FULL: begin
                if (dn_hs) begin
                    state_d = PS_HALF;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = PS_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase
        // Flush wins; an upstream handshake in this cycle is swallowed.
        if (flush_i) begin
            state_d = PS_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (stall && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PS_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            stall_q    <= '0;
            up_ready_q <= 1'b1;
            dn_valid_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            stall_q    <= stall_d;
            up_ready_q <= (state_d != PS_FULL);
            dn_valid_q <= (state_d != PS_EMPTY);
            occ_q      <= state_occupancy(state_d);
        end
    end

    assign up_ready_o  = up_ready_q;
    assign dn_valid_o  = dn_valid_q;
    assign dn_data_o   = main_q;
    assign occupancy_o = occ_q;
    assign stall_cnt_o = stall_q;

endmodule
